// File: rtl/flop_pipe_pkg.sv
// flop_pipe_pkg: shared defaults and count-width helper for the valid/ready register pipe
package flop_pipe_pkg;
  localparam int PIPE_WIDTH_DEFAULT = 32;
  localparam int PIPE_DEPTH_DEFAULT = 2;
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/flop_pipe_stage.sv
// pipe_stage: one valid bit and data register that loads when downstream has room
module pipe_stage
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  // flush drops only the valid bit; data moves only with a valid item so bubbles never toggle it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v <= 1'b0;
      d <= '0;
    end else if (clr) begin
      v <= 1'b0;
    end else if (ld) begin
      v <= v_in;
      if (v_in) d <= d_in;
    end
endmodule

// File: rtl/flop_pipe.sv
// flop_pipe: DEPTH-stage valid/ready register pipe with bubble collapsing and occupancy count
module flop_pipe
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEFAULT,
  parameter int DEPTH = PIPE_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [count_w(DEPTH)-1:0]   count
);
  localparam int CW = count_w(DEPTH);
  logic [DEPTH:0]   rdy;
  logic [DEPTH:0]   vsh;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] nv;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] d   [DEPTH];
  logic [WIDTH-1:0] din [DEPTH];
  assign vsh       = {v, in_valid};
  assign in_ready  = rdy[0] & ~clr & reset;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  // ready ripples from the output back; next-valid per stage feeds the registered popcount
  always_comb begin
    rdy[DEPTH] = out_ready;
    nv         = '0;
    cnt_nxt    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i]  = ~v[i] | rdy[i+1];
      nv[i]   = clr ? 1'b0 : rdy[i] ? vsh[i] : v[i];
      cnt_nxt = cnt_nxt + CW'(nv[i]);
    end
  end
  // occupancy tracks the stage valid bits edge for edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else count <= cnt_nxt;
  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    if (i == 0) begin : g_head
      assign din[i] = in_data;
    end else begin : g_tail
      assign din[i] = d[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk  (clk),
      .reset(reset),
      .clr  (clr),
      .ld   (rdy[i]),
      .v_in (vsh[i]),
      .d_in (din[i]),
      .v    (v[i]),
      .d    (d[i])
    );
  end
endmodule

// File: tb/tb_flop_pipe.sv
// tb_flop_pipe: directed vector table on DEPTH=3 plus randomized scoreboard on DEPTH 1,2,5
module tb_flop_pipe;
  import flop_pipe_pkg::*;
  localparam int DS[4] = '{3, 1, 2, 5};
  logic       clk, reset, clr, in_valid;
  logic [7:0] in_data;
  logic [3:0] in_ready, out_valid, out_ready;
  logic [7:0] out_data [4];
  logic [2:0] cnt [4];
  int tests = 0, fails = 0;
  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       cl;
    logic       eir;
    logic       eov;
    logic [7:0] eod;
    logic [2:0] ecnt;
  } vec_t;
  vec_t tv [21];
  logic [7:0] mem [4][16];
  int hd [4], tl [4], got [4];

  for (genvar g = 0; g < 4; g++) begin : u
    logic [count_w(DS[g])-1:0] c;
    assign cnt[g] = 3'(c);
    flop_pipe #(.WIDTH(8), .DEPTH(DS[g])) dut (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (in_ready[g]),
      .in_data  (in_data),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .count    (c)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    tv[0]  = '{1, 8'h11, 1, 0, 1, 0, 8'h00, 0};
    tv[1]  = '{1, 8'h22, 1, 0, 1, 0, 8'h00, 1};
    tv[2]  = '{1, 8'h33, 1, 0, 1, 0, 8'h00, 2};
    tv[3]  = '{0, 8'h00, 1, 0, 1, 1, 8'h11, 3};
    tv[4]  = '{0, 8'h00, 1, 0, 1, 1, 8'h22, 2};
    tv[5]  = '{0, 8'h00, 1, 0, 1, 1, 8'h33, 1};
    tv[6]  = '{0, 8'h00, 1, 0, 1, 0, 8'h33, 0};
    tv[7]  = '{1, 8'hA1, 0, 0, 1, 0, 8'h33, 0};
    tv[8]  = '{1, 8'hA2, 0, 0, 1, 0, 8'h33, 1};
    tv[9]  = '{1, 8'hA3, 0, 0, 1, 0, 8'h33, 2};
    tv[10] = '{1, 8'hA4, 0, 0, 0, 1, 8'hA1, 3};
    tv[11] = '{1, 8'hA4, 1, 0, 1, 1, 8'hA1, 3};
    tv[12] = '{0, 8'h00, 0, 0, 0, 1, 8'hA2, 3};
    tv[13] = '{0, 8'h00, 1, 0, 1, 1, 8'hA2, 3};
    tv[14] = '{1, 8'hB1, 1, 0, 1, 1, 8'hA3, 2};
    tv[15] = '{1, 8'hB2, 0, 0, 1, 1, 8'hA4, 2};
    tv[16] = '{0, 8'h00, 0, 0, 0, 1, 8'hA4, 3};
    tv[17] = '{0, 8'h00, 1, 0, 1, 1, 8'hA4, 3};
    tv[18] = '{1, 8'hC1, 0, 1, 0, 1, 8'hB1, 2};
    tv[19] = '{1, 8'hC1, 0, 0, 1, 0, 8'hB1, 0};
    tv[20] = '{0, 8'h00, 1, 0, 1, 0, 8'hB1, 1};
    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;
    #1;
    chk("rst_ir", 32'(in_ready[0]), 0);
    chk("rst_ov", 32'(out_valid[0]), 0);
    chk("rst_od", 32'(out_data[0]), 0);
    chk("rst_cnt", 32'(cnt[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      in_valid = tv[i].iv; in_data = tv[i].id; clr = tv[i].cl; out_ready = {4{tv[i].ordy}};
      #1;
      chk($sformatf("vec%0d_ir", i), 32'(in_ready[0]), 32'(tv[i].eir));
      chk($sformatf("vec%0d_ov", i), 32'(out_valid[0]), 32'(tv[i].eov));
      chk($sformatf("vec%0d_od", i), 32'(out_data[0]), 32'(tv[i].eod));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt[0]), 32'(tv[i].ecnt));
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h5A; clr = 1'b0; out_ready = '0;
    for (int n = 0; n < 8 && cnt[0] != 3; n++) @(negedge clk);
    #1;
    chk("full_cnt", 32'(cnt[0]), 3);
    chk("full_ov", 32'(out_valid[0]), 1);
    chk("full_ir", 32'(in_ready[0]), 0);
    #1 reset = 1'b0;
    #1;
    chk("async_ov", 32'(out_valid[0]), 0);
    chk("async_cnt", 32'(cnt[0]), 0);
    chk("async_od", 32'(out_data[0]), 0);
    chk("async_ir", 32'(in_ready[0]), 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin hd[k] = 0; tl[k] = 0; got[k] = 0; end
    for (int cyc = 0; cyc < 30000 && (got[0] < 1000 || got[1] < 1000 || got[2] < 1000 || got[3] < 1000); cyc++) begin
      @(negedge clk);
      in_valid = ($urandom % 4) != 0;
      in_data = 8'($urandom);
      clr = ($urandom % 64) == 0;
      for (int k = 0; k < 4; k++) out_ready[k] = ($urandom % 3) != 0;
      #1;
      for (int k = 0; k < 4; k++) begin
        int sz;
        logic er;
        sz = tl[k] - hd[k];
        er = (out_ready[k] || sz < DS[k]) && !clr;
        chk($sformatf("rnd%0d_ir", k), 32'(in_ready[k]), 32'(er));
        chk($sformatf("rnd%0d_cnt", k), 32'(cnt[k]), 32'(sz));
        if (sz == 0) chk($sformatf("rnd%0d_ov_empty", k), 32'(out_valid[k]), 0);
        else if (out_valid[k] && out_ready[k]) begin
          chk($sformatf("rnd%0d_data", k), 32'(out_data[k]), 32'(mem[k][hd[k] % 16]));
          hd[k]++;
          got[k]++;
        end
        if (clr) hd[k] = tl[k];
        else if (in_valid && er) begin
          mem[k][tl[k] % 16] = in_data;
          tl[k]++;
        end
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rnd%0d_items", k), 32'(got[k] >= 1000), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
